// File: rtl/restador_serial.sv
// Bit-serial N-bit subtractor (A - B), one full-subtractor cell plus a borrow flop.
// Optional macro RESTA_ABS_EN adds an ABS cycle that returns |A - B| with resta[N] = 0.
module restador_serial #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N:0]   resta,
    output logic         bout,
    output logic         neg
);

    localparam int CW = $clog2(N + 1);

`ifdef RESTA_ABS_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ABS, S_FIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN} state_t;
`endif

    state_t        r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_diff;
    logic          r_borrow;
    logic [CW-1:0] r_cnt;

    logic          w_a;
    logic          w_b;
    logic          w_d;
    logic          w_bo;
    logic          w_last;
    logic [N-1:0]  w_diff_next;
    logic [N:0]    w_diff_ext;

    always_comb begin
        w_a         = r_a[0];
        w_b         = r_b[0];
        w_d         = w_a ^ w_b ^ r_borrow;
        w_bo        = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
        w_last      = (r_cnt == CW'(N - 1));
        // Shift through an (N+1)-bit concatenation so N=1 needs no empty slice.
        w_diff_ext  = {w_d, r_diff} >> 1;
        w_diff_next = w_diff_ext[N-1:0];
    end

`ifdef RESTA_ABS_EN
    logic [N-1:0] w_neg_diff;
    always_comb w_neg_diff = ~r_diff + N'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            resta    <= '0;
            bout     <= 1'b0;
            neg      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        bout <= w_bo;
                        neg  <= w_bo;
`ifdef RESTA_ABS_EN
                        r_state <= S_ABS;
`else
                        resta   <= {w_bo, w_diff_next};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_FIN;
`endif
                    end
                end
`ifdef RESTA_ABS_EN
                S_ABS: begin
                    resta   <= {1'b0, (r_borrow ? w_neg_diff : r_diff)};
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_FIN;
                end
`endif
                S_FIN: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restador_serial.sv
// Self-checking bench for restador_serial at N=5 and N=1 against an arithmetic model.
module tb_restador_serial;

    localparam int N5 = 5;
    localparam int N1 = 1;
`ifdef RESTA_ABS_EN
    localparam int ABS = 1;
`else
    localparam int ABS = 0;
`endif
    localparam int LAT5 = N5 + ABS;
    localparam int LAT1 = N1 + ABS;

    logic        clk;
    logic        rst;
    logic        start5, start1;
    logic [4:0]  A5, B5;
    logic [0:0]  A1, B1;
    logic        busy5, done5, bout5, neg5;
    logic        busy1, done1, bout1, neg1;
    logic [5:0]  resta5;
    logic [1:0]  resta1;

    int tests = 0;
    int fails = 0;

    restador_serial #(.N(N5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .A(A5), .B(B5),
        .busy(busy5), .done(done5), .resta(resta5), .bout(bout5), .neg(neg5)
    );

    restador_serial #(.N(N1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1),
        .busy(busy1), .done(done1), .resta(resta1), .bout(bout1), .neg(neg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer subtraction, wrapped to n+1 bits, or magnitude in ABS mode.
    function automatic void model(input int n, input int a, input int b,
                                  output int r, output int bo, output int ng);
        bo = (a < b) ? 1 : 0;
        ng = bo;
        if (ABS != 0) r = (a < b) ? (b - a) : (a - b);
        else          r = (a - b + (1 << (n + 1))) % (1 << (n + 1));
    endfunction

    task automatic run5(input int a, input int b, output int lat, output bit busy_ok);
        @(negedge clk);
        A5 = 5'(a); B5 = 5'(b); start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (done5 !== 1'b1 && lat < 200) begin
            if (busy5 !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy5 !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic run1(input int a, input int b, output int lat);
        @(negedge clk);
        A1 = 1'(a); B1 = 1'(b); start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start5 = 1'b0; start1 = 1'b0;
        A5 = '0; B5 = '0; A1 = '0; B1 = '0;
        repeat (2) @(negedge clk);
        tests++; if (busy5 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy5); end
        tests++; if (done5 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done5); end
        tests++; if (resta5 !== 6'd0) begin fails++; $display("FAIL reset_resta got %0d want 0", resta5); end
        tests++; if (bout5 !== 1'b0 || neg5 !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b want 00", bout5, neg5); end
        tests++; if (resta1 !== 2'd0 || busy1 !== 1'b0) begin fails++; $display("FAIL reset_n1 got %b/%b want 00/0", resta1, busy1); end
        rst = 1'b0;
    endtask

    task automatic test_pairs5(input string name, input int a, input int b);
        int lat, r, bo, ng;
        bit bok;
        model(N5, a, b, r, bo, ng);
        run5(a, b, lat, bok);
        tests++; if (lat !== LAT5) begin fails++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT5); end
        tests++; if (!bok) begin fails++; $display("FAIL %s_busy got bad busy profile want high until done", name); end
        tests++; if (resta5 !== 6'(r)) begin fails++; $display("FAIL %s_resta A=%0d B=%0d got %0d want %0d", name, a, b, resta5, r); end
        tests++; if (bout5 !== 1'(bo) || neg5 !== 1'(ng)) begin fails++; $display("FAIL %s_flags got bout=%b neg=%b want %0d/%0d", name, bout5, neg5, bo, ng); end
        @(negedge clk);
        tests++; if (done5 !== 1'b0 || resta5 !== 6'(r)) begin fails++; $display("FAIL %s_pulse got done=%b resta=%0d want 0/%0d", name, done5, resta5, r); end
    endtask

    task automatic test_basic();
        test_pairs5("sub_pos", 20, 7);
        test_pairs5("sub_neg", 7, 20);
        test_pairs5("equal_max", 31, 31);
        test_pairs5("zero_minus_max", 0, 31);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            test_pairs5("random", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    endtask

    task automatic test_back_to_back();
        int w, gap;
        @(negedge clk);
        A5 = 5'd3; B5 = 5'd1; start5 = 1'b1;
        w = 0;
        while (done5 !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        tests++; if (done5 !== 1'b1) begin fails++; $display("FAIL b2b_first got no done want done"); end
        for (int p = 0; p < 3; p++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (done5 !== 1'b1 && gap < 100);
            tests++; if (gap !== LAT5 + 2) begin fails++; $display("FAIL b2b_period got %0d want %0d", gap, LAT5 + 2); end
            tests++; if (resta5 !== 6'd2 || busy5 !== 1'b0) begin fails++; $display("FAIL b2b_result got %0d busy=%b want 2 busy=0", resta5, busy5); end
        end
        start5 = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (busy5 !== 1'b0) begin fails++; $display("FAIL b2b_stop got busy=%b want 0", busy5); end
    endtask

    task automatic test_abort();
        int lat, seen;
        bit bok;
        @(negedge clk);
        A5 = 5'd20; B5 = 5'd7; start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if ({busy5, done5, bout5, neg5} !== 4'b0 || resta5 !== 6'd0) begin
            fails++; $display("FAIL abort_outputs got busy=%b done=%b resta=%0d bout=%b neg=%b want all 0", busy5, done5, resta5, bout5, neg5);
        end
        seen = 0;
        for (int i = 0; i < LAT5 + 4; i++) begin
            @(negedge clk);
            if (done5 === 1'b1) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
        run5(9, 4, lat, bok);
        tests++; if (lat !== LAT5 || resta5 !== 6'd5) begin fails++; $display("FAIL abort_recover got lat=%0d resta=%0d want %0d/5", lat, resta5, LAT5); end
        tests++; if (!bok) begin fails++; $display("FAIL abort_recover_busy got bad busy profile want high until done"); end
    endtask

    task automatic test_n1();
        int lat, r, bo, ng;
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                model(N1, a, b, r, bo, ng);
                run1(a, b, lat);
                tests++; if (lat !== LAT1) begin fails++; $display("FAIL n1_latency A=%0d B=%0d got %0d want %0d", a, b, lat, LAT1); end
                tests++; if (resta1 !== 2'(r) || bout1 !== 1'(bo) || neg1 !== 1'(ng)) begin
                    fails++; $display("FAIL n1_result A=%0d B=%0d got %b/%b/%b want %0d/%0d/%0d", a, b, resta1, bout1, neg1, r, bo, ng);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_abort();
        test_n1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
